offset_index_decoder: RTL
=========================

Name: offset_index_decoder

Overview:
- Inverse of the speech-symbol encoder. The encoder maps a symbol index 1..NUM_IDX to a record byte offset (idx-1)*REC_BYTES.
- This block recovers the symbol index from a record offset, so the back-end (word matcher / output formatter) gets a symbol index instead of a memory offset.
- Streaming block with valid/ready handshakes on both sides, a 2-entry elastic buffer (output register plus skid) for full throughput, per-item error tagging and a saturating error counter.

Parameters:
- REC_BYTES, 8, bytes per record. Must be a power of two.
- NUM_IDX, 20, number of valid symbol indices (1..NUM_IDX).
- W, 8, width of the offset and index buses.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-low.
- in_valid  input  1  upstream offset valid.
- in_ready  output  1  block can accept; driven from a register.
- in_off  input  W  record byte offset.
- out_valid  output  1  decoded item valid.
- out_ready  input  1  downstream accepts.
- out_idx  output  W  recovered index; 0 when out_err=1.
- out_err  output  1  offset misaligned or out of range.
- err_cnt  output  W  saturating count of errored items accepted.
- clr_err  input  1  clears err_cnt.

Behaviour:
- Reset (rst=0 at a clk edge):
  - out_valid=0, out_idx=0, out_err=0, err_cnt=0, in_ready=1.
  - State goes to EMPTY and all buffered data is discarded.
  - Reset mid-transfer drops items; no partial output follows reset.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Decode rule (combinational on in_off, registered at acceptance):
  - Valid when in_off mod REC_BYTES == 0 and in_off <= (NUM_IDX-1)*REC_BYTES, i.e. 0..152 with defaults. Then idx = in_off/REC_BYTES + 1, err=0.
  - Otherwise idx=0, err=1.
  - Offset 0 decodes to index 1.
  - Division and modulo are shift and mask only; no divider.
- Latency: an accepted item appears on out_* on the next cycle if the output register is empty or draining.
- States:
  - EMPTY: out_valid=0, in_ready=1.
    - Input transfer -> load output register -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input and output transfer together: load output register -> ONE.
    - Input transfer only: load skid -> TWO.
    - Output transfer only -> EMPTY.
    - Neither: hold.
  - TWO: out_valid=1, in_ready=0.
    - Output transfer: move skid to output register -> ONE.
    - Otherwise hold.
- Ordering and stability:
  - Order is strictly preserved.
  - out_idx and out_err stay stable while out_valid=1 and out_ready=0.
- Throughput: one item per cycle while out_ready=1.
- err_cnt:
  - Increments by 1 on each input transfer whose decode has err=1. It counts at acceptance, not emission.
  - Saturates at 2^W-1.
  - clr_err and an errored acceptance in the same cycle: err_cnt=1.
  - clr_err alone: err_cnt=0.
- in_ready depends only on state, never combinationally on out_ready.

Decomposition:
- Shared package holds:
  - REC_BYTES, NUM_IDX and log2(REC_BYTES) constants.
  - MAX_OFF = (NUM_IDX-1)*REC_BYTES.
  - The state enum {EMPTY, ONE, TWO}.
  - An item struct {idx, err}.
  - The encoder should take its constants from the same package.
- One sub-module: offset_decode_comb, the pure combinational offset -> {idx, err} function. The handshake/skid logic stays in the top module.

Test Plan:
- Reset check: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, err_cnt=0, in_ready=1; no output after rst rises until a new input is accepted.
- Full range: offsets 0,8,...,152 with out_ready=1 -> out_idx 1..20 in order, each 1 cycle after acceptance, out_err=0, err_cnt=0.
- Errored offsets: 4, 153, 160, 255 -> each gives out_idx=0, out_err=1; err_cnt=4.
- Backpressure: out_ready=0, send 16 then 24 -> in_ready=0 after the second; out_idx=3 held stable; release out_ready -> 3 then 4, no loss or duplication.
- Random valid/ready toggling over 1000 items, checked against a reference model -> exact ordered match.
- Saturation and clear: 300 errored offsets -> err_cnt=255. Then clr_err together with offset 7 accepted -> err_cnt=1; clr_err alone -> err_cnt=0.

Source files
------------

// File: rtl/offset_index_decoder_pkg.sv
// rtl/offset_index_decoder_pkg.sv - shared constants and types for the record-offset to symbol-index decoder
//
// Purpose: single home for the record geometry shared by the speech-symbol
// encoder and this decoder, the decoder FSM state type and the decoded item.
// Ports: none (package).

package offset_index_decoder_pkg;

   localparam int W         = 8;                          // offset / index bus width
   localparam int REC_BYTES = 8;                          // bytes per record, power of two
   localparam int NUM_IDX   = 20;                         // valid indices are 1..NUM_IDX
   localparam int OFF_SHIFT = $clog2(REC_BYTES);          // log2(REC_BYTES)
   localparam int MAX_OFF   = (NUM_IDX - 1) * REC_BYTES;  // offset of the last record

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } state_t;

   typedef struct packed {
      logic [W-1:0] idx;
      logic         err;
   } item_t;

endpackage

// File: rtl/offset_index_decoder_if.sv
// rtl/offset_index_decoder_if.sv - offset-in / index-out stream interface
//
// Purpose: groups the input offset stream and the output index stream.
// Signals:
//   in_valid, in_off   upstream offset stream (master drives)
//   in_ready           decoder can accept (slave drives)
//   out_valid, out_idx, out_err   decoded item stream (slave drives)
//   out_ready          downstream accepts (master drives)

interface offset_index_decoder_if;
   import offset_index_decoder_pkg::*;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_off;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic         out_err;

   modport master (
      output in_valid, in_off, out_ready,
      input  in_ready, out_valid, out_idx, out_err
   );

   modport slave (
      input  in_valid, in_off, out_ready,
      output in_ready, out_valid, out_idx, out_err
   );

endinterface

// File: rtl/offset_decode_comb.sv
// rtl/offset_decode_comb.sv - combinational record offset to symbol index function
//
// Purpose: maps a record byte offset to {idx, err}. Aligned offsets within
// 0..MAX_OFF give idx = off/REC_BYTES + 1; anything else gives idx=0, err=1.
// Ports:
//   off   input  W      record byte offset
//   item  output item_t decoded {idx, err}

module offset_decode_comb
   import offset_index_decoder_pkg::*;
(
   input  logic [W-1:0] off,
   output item_t        item
);

   localparam logic [W-1:0] ALIGN_MASK = W'(REC_BYTES - 1);
   localparam logic [W-1:0] LAST_OFF   = W'(MAX_OFF);

   logic aligned;
   logic in_range;

   // REC_BYTES is a power of two, so modulo is a mask and division a shift.
   assign aligned  = (off & ALIGN_MASK) == '0;
   assign in_range = off <= LAST_OFF;

   always_comb begin
      item.idx = '0;
      item.err = 1'b1;
      if (aligned && in_range) begin
         item.idx = (off >> OFF_SHIFT) + W'(1);
         item.err = 1'b0;
      end
   end

endmodule

// File: rtl/offset_index_decoder.sv
// rtl/offset_index_decoder.sv - streaming record offset to symbol index decoder
//
// Purpose: recovers the symbol index from a record offset and passes it on
// through a 2-entry elastic buffer (output register + skid) so the stream
// runs at one item per cycle. Errored items are tagged and counted.
// Ports:
//   clk      input   rising-edge clock
//   rst      input   synchronous, active-low reset
//   bus      slave   offset in / index out stream
//   clr_err  input   clears err_cnt
//   err_cnt  output  saturating count of errored items accepted

module offset_index_decoder
   import offset_index_decoder_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   offset_index_decoder_if.slave bus,
   input  logic                  clr_err,
   output logic [W-1:0]          err_cnt
);

   state_t state;
   item_t  out_q;
   item_t  skid_q;
   item_t  dec;
   logic   in_ready_q;
   logic   out_valid_q;
   logic   in_xfer;
   logic   out_xfer;

   offset_decode_comb u_decode (
      .off  (bus.in_off),
      .item (dec)
   );

   assign in_xfer  = bus.in_valid & in_ready_q;
   assign out_xfer = out_valid_q & bus.out_ready;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_idx   = out_q.idx;
   assign bus.out_err   = out_q.err;

   // in_ready and out_valid are registered alongside the state so that
   // in_ready never sees out_ready combinationally; the skid absorbs the
   // one item that can arrive in the cycle the output stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         skid_q      <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  out_q       <= dec;
                  out_valid_q <= 1'b1;
                  state       <= ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  out_q <= dec;
               end else if (in_xfer) begin
                  skid_q     <= dec;
                  in_ready_q <= 1'b0;
                  state      <= TWO;
               end else if (out_xfer) begin
                  out_valid_q <= 1'b0;
                  state       <= EMPTY;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  out_q      <= skid_q;
                  in_ready_q <= 1'b1;
                  state      <= ONE;
               end
            end
            default: begin
               state       <= EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Counts at acceptance; a clear in the same cycle as an errored
   // acceptance leaves exactly that one error counted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_cnt <= '0;
      end else if (clr_err) begin
         err_cnt <= (in_xfer && dec.err) ? W'(1) : '0;
      end else if (in_xfer && dec.err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + W'(1);
      end
   end

endmodule
